// File: rtl/peri_bus_pkg.sv
// -----------------------------------------------------------------------------
// peri_bus_pkg
// Shared types and constants for the peripheral bus bridge and any future
// bus-matrix blocks that reuse the slot decoder.
//   br_state_e  : bridge FSM states
//   peri_req_t  : latched host request (we/be/addr/wdata)
//   ERR_DATA    : default read data returned on error responses
// -----------------------------------------------------------------------------
package peri_bus_pkg;

    typedef enum logic [1:0] {
        BR_IDLE   = 2'd0,
        BR_ACCESS = 2'd1,
        BR_RESP   = 2'd2
    } br_state_e;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } peri_req_t;

    localparam logic [31:0] ERR_DATA = 32'hBADC_0DE5;

endpackage

// File: rtl/peri_slot_decode.sv
// -----------------------------------------------------------------------------
// peri_slot_decode
// Combinational peripheral address decoder: extracts the slot index from a
// peripheral-relative byte address and flags whether that slot exists.
// Ports:
//   i_addr   in  32        peripheral-relative byte address
//   o_slot   out SlotIdxW  slot index = i_addr[SlotShift +: SlotIdxW]
//   o_mapped out 1         index < NumSlots
// Requires SlotShift >= 1 and SlotShift + SlotIdxW <= 31.
// -----------------------------------------------------------------------------
module peri_slot_decode #(
    parameter int NumSlots  = 4,
    parameter int SlotShift = 12,
    parameter int SlotIdxW  = 4
) (
    input  logic [31:0]         i_addr,
    output logic [SlotIdxW-1:0] o_slot,
    output logic                o_mapped
);

    // In-slot offset and bits above the index field do not affect decoding.
    logic w_unused_addr;

    assign o_slot        = i_addr[SlotShift +: SlotIdxW];
    // Compare at 32 bits so NumSlots larger than the index range maps all.
    assign o_mapped      = ({{(32-SlotIdxW){1'b0}}, o_slot} < 32'(NumSlots));
    assign w_unused_addr = ^{i_addr[31:SlotShift+SlotIdxW], i_addr[SlotShift-1:0]};

endmodule

// File: rtl/peri_bus_bridge.sv
// -----------------------------------------------------------------------------
// peri_bus_bridge
// Bridges one Ibex-style peripheral data request at a time onto NumSlots
// device slots with a req/ready handshake and returns a one-cycle rvalid.
// Unmapped slots (and, with PERI_BRIDGE_TIMEOUT_EN defined, devices that
// stall for TimeoutCycles) complete with ErrData plus an err_o pulse.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   host_req/we/be/addr/wdata   request from the core
//   host_gnt          combinational accept (IDLE only)
//   host_rvalid/rdata registered response, rdata 0 for writes
//   dev_req           registered one-hot device request
//   dev_we/be/addr/wdata        registered request fields (addr = in-slot offset)
//   dev_ready/rdata   device completion and packed read data (slot i at [32i+:32])
//   err_o             error pulse with the error rvalid
//   err_addr_o        sticky address of the latest error
// Optional macro: PERI_BRIDGE_TIMEOUT_EN (ACCESS stall timeout, TimeoutCycles >= 1).
// -----------------------------------------------------------------------------
module peri_bus_bridge
    import peri_bus_pkg::*;
#(
    parameter int          NumSlots      = 4,
    parameter int          SlotShift     = 12,
    parameter int          SlotIdxW      = 4,
    parameter logic [31:0] ErrData       = ERR_DATA,
    parameter int          TimeoutCycles = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   host_req,
    input  logic                   host_we,
    input  logic [3:0]             host_be,
    input  logic [31:0]            host_addr,
    input  logic [31:0]            host_wdata,
    output logic                   host_gnt,
    output logic                   host_rvalid,
    output logic [31:0]            host_rdata,
    output logic [NumSlots-1:0]    dev_req,
    output logic                   dev_we,
    output logic [3:0]             dev_be,
    output logic [SlotShift-1:0]   dev_addr,
    output logic [31:0]            dev_wdata,
    input  logic [NumSlots-1:0]    dev_ready,
    input  logic [32*NumSlots-1:0] dev_rdata,
    output logic                   err_o,
    output logic [31:0]            err_addr_o
);

    br_state_e             r_state;
    br_state_e             w_state_next;
    peri_req_t             r_req;
    logic [SlotIdxW-1:0]   r_slot;
    logic [NumSlots-1:0]   r_dev_req;
    logic                  r_rvalid;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic [31:0]           r_err_addr;

    logic [SlotIdxW-1:0]   w_dec_slot;
    logic                  w_dec_mapped;
    logic                  w_accept;
    logic                  w_sel_ready;
    logic [31:0]           w_sel_rdata;
    logic                  w_timeout;
    logic                  w_to_resp;
    logic                  w_resp_err;
    logic [31:0]           w_resp_data;
    logic [31:0]           w_resp_addr;
    logic                  w_dev_en;
    logic [SlotIdxW-1:0]   w_dev_slot;
    logic [NumSlots-1:0]   w_dev_req_next;

    peri_slot_decode #(
        .NumSlots  (NumSlots),
        .SlotShift (SlotShift),
        .SlotIdxW  (SlotIdxW)
    ) u_decode (
        .i_addr   (host_addr),
        .o_slot   (w_dec_slot),
        .o_mapped (w_dec_mapped)
    );

    // Grant is combinational so the core sees acceptance in the request cycle.
    assign w_accept = (r_state == BR_IDLE) && host_req && !rst;

    // Select ready/rdata of the latched slot; other slots' ready is ignored.
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_rdata = 32'h0000_0000;
        for (int i = 0; i < NumSlots; i++) begin
            w_sel_ready = w_sel_ready | (dev_ready[i] & (r_slot == SlotIdxW'(i)));
            w_sel_rdata = w_sel_rdata | (dev_rdata[i*32 +: 32] & {32{r_slot == SlotIdxW'(i)}});
        end
    end

`ifdef PERI_BRIDGE_TIMEOUT_EN
    localparam int CntW = ($clog2(TimeoutCycles + 1) > 8) ? $clog2(TimeoutCycles + 1) : 8;
    logic [CntW-1:0] r_cnt;

    // Stall counter: zero outside ACCESS, counts ACCESS cycles without ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state != BR_ACCESS) begin
            r_cnt <= '0;
        end else if (!w_sel_ready) begin
            r_cnt <= r_cnt + CntW'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Fires in the TimeoutCycles-th stalled cycle; a same-cycle ready wins.
    assign w_timeout = (r_state == BR_ACCESS) && !w_sel_ready &&
                       (r_cnt == CntW'(TimeoutCycles - 1));
`else
    localparam int unused_timeout_cycles = TimeoutCycles;
    assign w_timeout = 1'b0;
`endif

    // Next-state and response selection for the IDLE/ACCESS/RESP sequence.
    always_comb begin
        w_state_next = r_state;
        w_to_resp    = 1'b0;
        w_resp_err   = 1'b0;
        w_resp_data  = 32'h0000_0000;
        w_resp_addr  = r_req.addr;
        w_dev_en     = 1'b0;
        w_dev_slot   = r_slot;
        case (r_state)
            BR_IDLE: begin
                if (host_req) begin
                    w_resp_addr = host_addr;
                    if (w_dec_mapped) begin
                        w_state_next = BR_ACCESS;
                        w_dev_en     = 1'b1;
                        w_dev_slot   = w_dec_slot;
                    end else begin
                        // Unmapped: skip ACCESS and answer with an error next cycle.
                        w_state_next = BR_RESP;
                        w_to_resp    = 1'b1;
                        w_resp_err   = 1'b1;
                        w_resp_data  = ErrData;
                    end
                end else begin
                    w_state_next = BR_IDLE;
                end
            end
            BR_ACCESS: begin
                if (w_sel_ready) begin
                    w_state_next = BR_RESP;
                    w_to_resp    = 1'b1;
                    w_resp_data  = r_req.we ? 32'h0000_0000 : w_sel_rdata;
                end else if (w_timeout) begin
                    w_state_next = BR_RESP;
                    w_to_resp    = 1'b1;
                    w_resp_err   = 1'b1;
                    w_resp_data  = ErrData;
                end else begin
                    w_state_next = BR_ACCESS;
                    w_dev_en     = 1'b1;
                end
            end
            BR_RESP: begin
                w_state_next = BR_IDLE;
            end
            default: begin
                w_state_next = BR_IDLE;
            end
        endcase
    end

    // One-hot device request for the slot that will be in ACCESS next cycle.
    always_comb begin
        w_dev_req_next = '0;
        for (int i = 0; i < NumSlots; i++) begin
            w_dev_req_next[i] = w_dev_en && (w_dev_slot == SlotIdxW'(i));
        end
    end

    // State, latched request and registered host/device outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= BR_IDLE;
            r_req      <= '0;
            r_slot     <= '0;
            r_dev_req  <= '0;
            r_rvalid   <= 1'b0;
            r_rdata    <= 32'h0000_0000;
            r_err      <= 1'b0;
            r_err_addr <= 32'h0000_0000;
        end else begin
            r_state   <= w_state_next;
            r_dev_req <= w_dev_req_next;
            r_rvalid  <= w_to_resp;
            r_err     <= w_to_resp & w_resp_err;
            if (w_accept) begin
                r_req.we    <= host_we;
                r_req.be    <= host_be;
                r_req.addr  <= host_addr;
                r_req.wdata <= host_wdata;
                r_slot      <= w_dec_slot;
            end
            // rdata holds between responses; only a response reloads it.
            if (w_to_resp) begin
                r_rdata <= w_resp_data;
            end
            if (w_to_resp && w_resp_err) begin
                r_err_addr <= w_resp_addr;
            end
        end
    end

    assign host_gnt    = w_accept;
    assign host_rvalid = r_rvalid;
    assign host_rdata  = r_rdata;
    assign dev_req     = r_dev_req;
    assign dev_we      = r_req.we;
    assign dev_be      = r_req.be;
    assign dev_addr    = r_req.addr[SlotShift-1:0];
    assign dev_wdata   = r_req.wdata;
    assign err_o       = r_err;
    assign err_addr_o  = r_err_addr;

endmodule

// File: tb/tb_peri_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_peri_bus_bridge
// Directed bench for peri_bus_bridge. Stimulus pushes expected responses into
// a queue; a negedge monitor pops one entry per host_rvalid and compares.
// Cycle-exact handshake checks are made inline by the stimulus process.
// Honours PERI_BRIDGE_TIMEOUT_EN (bridge built with TimeoutCycles = 8).
// -----------------------------------------------------------------------------
module tb_peri_bus_bridge;

    localparam int          NSLOT   = 4;
    localparam logic [31:0] ERRDATA = 32'hBADC_0DE5;

    logic         clk;
    logic         rst;
    logic         host_req;
    logic         host_we;
    logic [3:0]   host_be;
    logic [31:0]  host_addr;
    logic [31:0]  host_wdata;
    logic         host_gnt;
    logic         host_rvalid;
    logic [31:0]  host_rdata;
    logic [3:0]   dev_req;
    logic         dev_we;
    logic [3:0]   dev_be;
    logic [11:0]  dev_addr;
    logic [31:0]  dev_wdata;
    logic [3:0]   dev_ready;
    logic [127:0] dev_rdata;
    logic         err_o;
    logic [31:0]  err_addr_o;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests;
    int   n_fail;
    int   n_rvalid;
    int   snap;

    peri_bus_bridge #(
        .NumSlots      (NSLOT),
        .SlotShift     (12),
        .SlotIdxW      (4),
        .ErrData       (ERRDATA),
        .TimeoutCycles (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_be     (host_be),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .dev_req     (dev_req),
        .dev_we      (dev_we),
        .dev_be      (dev_be),
        .dev_addr    (dev_addr),
        .dev_wdata   (dev_wdata),
        .dev_ready   (dev_ready),
        .dev_rdata   (dev_rdata),
        .err_o       (err_o),
        .err_addr_o  (err_addr_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] data, input logic err, input logic [31:0] addr);
        exp_t e;
        e.data = data;
        e.err  = err;
        e.addr = addr;
        exp_q.push_back(e);
    endtask

    // Drive a request in the current cycle and check the combinational grant.
    task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, input string name);
        host_req   = 1'b1;
        host_we    = we;
        host_be    = be;
        host_addr  = addr;
        host_wdata = wdata;
        #1;
        check(name, 32'(host_gnt), 32'd1);
    endtask

    // Response monitor: one queue entry per rvalid pulse.
    always @(negedge clk) begin
        if (host_rvalid) begin
            n_rvalid++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rvalid: got rdata 0x%08h, expected no response", host_rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("mon_rdata", host_rdata, e.data);
                check("mon_err_o", 32'(err_o), 32'(e.err));
                if (e.err) begin
                    check("mon_err_addr", err_addr_o, e.addr);
                end
            end
        end
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        n_rvalid   = 0;
        rst        = 1'b1;
        host_req   = 1'b1;
        host_we    = 1'b0;
        host_be    = 4'h0;
        host_addr  = 32'h0000_0000;
        host_wdata = 32'h0000_0000;
        dev_ready  = 4'h0;
        dev_rdata  = {32'h0BEE_0003, 32'hCAFE_0002, 32'h1234_5678, 32'hDEAD_BEEF};

        // Reset: outputs zero, no grant even with a request pending.
        step();
        step();
        check("rst_gnt", 32'(host_gnt), 32'd0);
        check("rst_rvalid", 32'(host_rvalid), 32'd0);
        check("rst_rdata", host_rdata, 32'd0);
        check("rst_dev_req", 32'(dev_req), 32'd0);
        check("rst_err_o", 32'(err_o), 32'd0);
        check("rst_err_addr", err_addr_o, 32'd0);
        host_req = 1'b0;
        rst      = 1'b0;
        step();

        // Read slot 1, device ready in cycle 1.
        issue(1'b0, 4'hF, 32'h0000_1010, 32'h0, "rd1_gnt");
        push_exp(32'h1234_5678, 1'b0, 32'h0);
        step();
        host_req = 1'b0;
        check("rd1_dev_req", 32'(dev_req), 32'h2);
        check("rd1_dev_addr", 32'(dev_addr), 32'h010);
        check("rd1_dev_we", 32'(dev_we), 32'd0);
        check("rd1_gnt_access", 32'(host_gnt), 32'd0);
        dev_ready = 4'b0010;
        step();
        dev_ready = 4'h0;
        check("rd1_rvalid_c2", 32'(host_rvalid), 32'd1);
        check("rd1_dev_req_resp", 32'(dev_req), 32'd0);
        step();
        check("rd1_rvalid_c3", 32'(host_rvalid), 32'd0);

        // Write slot 0 with a 5-cycle device stall.
        issue(1'b1, 4'b0011, 32'h0000_0004, 32'hA5A5_0000, "wr0_gnt");
        push_exp(32'h0, 1'b0, 32'h0);
        step();
        host_req = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            check("wr0_dev_req", 32'(dev_req), 32'h1);
            check("wr0_dev_wdata", dev_wdata, 32'hA5A5_0000);
            check("wr0_dev_be", 32'(dev_be), 32'h3);
            check("wr0_rvalid_early", 32'(host_rvalid), 32'd0);
            if (k == 5) dev_ready = 4'b0001;
            // A ready on a non-selected slot must be ignored.
            else if (k == 2) dev_ready = 4'b0100;
            else dev_ready = 4'h0;
            step();
        end
        dev_ready = 4'h0;
        check("wr0_rvalid", 32'(host_rvalid), 32'd1);
        check("wr0_dev_req_resp", 32'(dev_req), 32'd0);
        step();
        check("wr0_single_rvalid", 32'(host_rvalid), 32'd0);

        // Unmapped slot 7: error response in cycle 1.
        issue(1'b0, 4'hF, 32'h0000_7000, 32'h0, "unm_gnt");
        push_exp(ERRDATA, 1'b1, 32'h0000_7000);
        step();
        host_req = 1'b0;
        check("unm_dev_req", 32'(dev_req), 32'd0);
        check("unm_rvalid", 32'(host_rvalid), 32'd1);
        check("unm_err_o", 32'(err_o), 32'd1);
        step();
        check("unm_err_o_pulse", 32'(err_o), 32'd0);
        check("unm_err_addr_sticky", err_addr_o, 32'h0000_7000);

        // Back-to-back reads to slots 2 and 3 with host_req held.
        issue(1'b0, 4'hF, 32'h0000_2000, 32'h0, "b2b_gnt0");
        push_exp(32'hCAFE_0002, 1'b0, 32'h0);
        step();
        host_addr = 32'h0000_3008;
        check("b2b_gnt_access", 32'(host_gnt), 32'd0);
        check("b2b_dev_req0", 32'(dev_req), 32'h4);
        dev_ready = 4'b0100;
        step();
        dev_ready = 4'h0;
        check("b2b_gnt_resp", 32'(host_gnt), 32'd0);
        check("b2b_rvalid0", 32'(host_rvalid), 32'd1);
        step();
        check("b2b_gnt1_c3", 32'(host_gnt), 32'd1);
        push_exp(32'h0BEE_0003, 1'b0, 32'h0);
        step();
        host_req = 1'b0;
        check("b2b_dev_req1", 32'(dev_req), 32'h8);
        check("b2b_dev_addr1", 32'(dev_addr), 32'h008);
        dev_ready = 4'b1000;
        step();
        dev_ready = 4'h0;
        check("b2b_rvalid1", 32'(host_rvalid), 32'd1);
        step();

        // Device that never readies.
        issue(1'b0, 4'hF, 32'h0000_1000, 32'h0, "to_gnt");
`ifdef PERI_BRIDGE_TIMEOUT_EN
        push_exp(ERRDATA, 1'b1, 32'h0000_1000);
        for (int k = 1; k <= 8; k++) begin
            step();
            host_req = 1'b0;
            check("to_dev_req_held", 32'(dev_req), 32'h2);
            check("to_no_rvalid", 32'(host_rvalid), 32'd0);
        end
        step();
        check("to_dev_req_drop", 32'(dev_req), 32'd0);
        check("to_rvalid", 32'(host_rvalid), 32'd1);
        check("to_err_o", 32'(err_o), 32'd1);
        step();
`else
        snap = n_rvalid;
        step();
        host_req = 1'b0;
        for (int k = 0; k < 1000; k++) step();
        check("to_still_access", 32'(dev_req), 32'h2);
        check("to_no_rvalid", 32'(n_rvalid), 32'(snap));
        push_exp(32'h1234_5678, 1'b0, 32'h0);
        dev_ready = 4'b0010;
        step();
        dev_ready = 4'h0;
        check("to_late_rvalid", 32'(host_rvalid), 32'd1);
        step();
`endif

        // Reset in the second ACCESS cycle of a write; no response may follow.
        issue(1'b1, 4'hF, 32'h0000_2ABC, 32'h1111_2222, "rst_mid_gnt");
        step();
        host_req = 1'b0;
        step();
        check("rst_mid_dev_we", 32'(dev_we), 32'd1);
        snap = n_rvalid;
        rst  = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_dev_req", 32'(dev_req), 32'd0);
        check("rst_mid_dev_we0", 32'(dev_we), 32'd0);
        check("rst_mid_dev_be", 32'(dev_be), 32'd0);
        check("rst_mid_dev_addr", 32'(dev_addr), 32'd0);
        check("rst_mid_dev_wdata", dev_wdata, 32'd0);
        check("rst_mid_rvalid", 32'(host_rvalid), 32'd0);
        check("rst_mid_rdata", host_rdata, 32'd0);
        check("rst_mid_err_addr", err_addr_o, 32'd0);
        step();
        step();
        check("rst_mid_no_rvalid", 32'(n_rvalid), 32'(snap));

        // Normal transaction after the reset.
        issue(1'b0, 4'hF, 32'h0000_3004, 32'h0, "post_rst_gnt");
        push_exp(32'h0BEE_0003, 1'b0, 32'h0);
        step();
        host_req = 1'b0;
        check("post_rst_dev_addr", 32'(dev_addr), 32'h004);
        dev_ready = 4'b1000;
        step();
        dev_ready = 4'h0;
        check("post_rst_rvalid", 32'(host_rvalid), 32'd1);
        step();
        step();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/peri_bus_bridge.md
Name: peri_bus_bridge

Overview:
Downstream of the core complex's peripheral port (peri_addr/req/write/be/wdata/gnt/rvalid/rdata).
- Accepts one Ibex-style data request at a time and decodes the peripheral-relative address into one of NumSlots device slots.
- Drives a simple req/ready handshake to the selected device and returns a single-cycle rvalid with read data.
- Unmapped accesses, and stalled accesses when the timeout is compiled in, complete with an error response so the core never hangs.

Parameters:
NumSlots, 4, number of device slots; must be >= 1.
SlotShift, 12, log2 of the slot size in bytes; slot index = addr[SlotShift +: SlotIdxW].
SlotIdxW, 4, slot index width; index >= NumSlots is unmapped.
ErrData, 32'hBADC_0DE5, rdata returned on error responses.
TimeoutCycles, 255, ACCESS cycles before forced error; only used with the optional feature.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
host_req  in  1  request from core (peri_req)
host_we  in  1  write enable (peri_write)
host_be  in  4  byte enables
host_addr  in  32  peripheral-relative byte address
host_wdata  in  32  write data
host_gnt  out  1  request accepted
host_rvalid  out  1  response valid, one-cycle pulse
host_rdata  out  32  read data; 0 for writes
dev_req  out  NumSlots  one-hot request to device
dev_we  out  1  registered write enable
dev_be  out  4  registered byte enables
dev_addr  out  SlotShift  registered in-slot offset
dev_wdata  out  32  registered write data
dev_ready  in  NumSlots  device completes access
dev_rdata  in  32*NumSlots  device read data, valid with dev_ready
err_o  out  1  one-cycle pulse coincident with an error rvalid
err_addr_o  out  32  address of most recent error, sticky

Behaviour:
- Reset (clk, rst synchronous active-high): state IDLE. All outputs 0: host_gnt, host_rvalid, host_rdata, dev_*, err_o, err_addr_o.
- One outstanding transaction only.
- IDLE:
  - host_gnt = host_req, combinational, same cycle.
  - On host_req, register we/be/addr/wdata and slot index.
  - Slot mapped -> ACCESS; unmapped -> RESP with error flag set.
- ACCESS:
  - dev_req[slot] held high; all other dev_req bits 0.
  - dev_* outputs stable from the registers; host_gnt = 0.
  - On dev_ready[slot]: capture dev_rdata[slot] if read (0 if write), clear error flag, -> RESP.
  - dev_ready on a non-selected slot is ignored.
- RESP:
  - host_rvalid = 1 for exactly one cycle; host_rdata = captured data or ErrData on error.
  - On error, err_o = 1 and err_addr_o is loaded with the registered address.
  - -> IDLE; host_gnt = 0 in this cycle.
  - host_rvalid and host_rdata are registered outputs.
- Latency: grant in cycle 0; earliest dev_ready in cycle 1; rvalid in cycle 2. Back-to-back: next gnt earliest cycle 3.
- Unmapped access: gnt cycle 0, rvalid+err cycle 1 (skips ACCESS).
- host_req deasserting during ACCESS/RESP has no effect; the latched request completes.
- rst mid-transaction: immediate return to IDLE, dev_req dropped, no rvalid issued.
- host_rdata holds its last value outside rvalid; the bench checks it only with rvalid.

Optional Feature:
PERI_BRIDGE_TIMEOUT_EN:
- Defined: an 8+ bit counter clears on ACCESS entry and increments each ACCESS cycle without dev_ready[slot].
  - On reaching TimeoutCycles, dev_req drops and the block -> RESP with error (ErrData, err_o).
  - dev_ready in the same cycle as the timeout wins (normal completion).
- Undefined: no counter; ACCESS waits indefinitely; TimeoutCycles unused.

Decomposition:
- Package peri_bus_pkg:
  - typedef enum logic [1:0] {BR_IDLE, BR_ACCESS, BR_RESP} br_state_e.
  - Struct peri_req_t {we, be, addr, wdata}.
  - Default ERR_DATA constant.
- Sub-module peri_slot_decode: combinational addr -> slot index + mapped flag, reusable by future bus matrices.
- FSM and datapath live in the top.

Test Plan:
- Read slot 1 (addr 0x0000_1010), device readies in cycle 1 with 0x1234_5678 -> gnt cycle 0, dev_req=4'b0010, dev_addr=0x010, rvalid cycle 2, rdata=0x1234_5678, err_o=0.
- Write slot 0 (addr 0x4, be=4'b0011, wdata=0xA5A5_0000), ready after 5-cycle stall -> dev_req held 5 cycles with stable dev_wdata/be, single rvalid, rdata=0.
- Unmapped addr 0x0000_7000 with NumSlots=4 -> gnt cycle 0, no dev_req, rvalid+err_o cycle 1, rdata=0xBADC_0DE5, err_addr_o=0x7000.
- Back-to-back: host_req held for two reads to slots 2 and 3 -> second gnt not before cycle 3, no gnt during ACCESS/RESP, two rvalid pulses in order.
- Timeout (macro on, TimeoutCycles=8), device never readies -> dev_req high 8 cycles then low, rvalid with ErrData and err_o; macro off -> still in ACCESS after 1000 cycles.
- rst asserted in ACCESS cycle 2 -> next cycle all outputs 0, no rvalid; a subsequent request completes normally.
